dct_2d: RTL and testbench

Pipelined 8×8 two-dimensional forward DCT-II over one packed block of signed samples. It is used by the image path, which tiles a frame into 8×8 windows, feeds one window per transfer, and scatters the returned coefficients back into the frame. The block is separable: an 8-point row pass, a registered transpose, then an 8-point column pass. It accepts one block per clock.

---
 rtl/dct2d_pkg.sv | 31 +++
 rtl/dct_2d_dct1d.sv | 46 ++++
 rtl/dct_2d.sv | 101 ++++++++++
 tb/tb_dct_2d.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/dct2d_pkg.sv
// dct2d_pkg: shared constants for the 8x8 forward DCT-II.
//   COEF_W    width of one fixed-point cosine coefficient
//   GUARD_C   extra bits carried by the row pass and the accumulators
//   ROUND_C   rounding offset added before the arithmetic shift
//   SHIFT_C   fixed-point scale of the coefficient table (2^11)
//   K_TABLE   K[k][x] = round(2048 * 0.5 * C(k) * cos((2x+1)k*pi/16))
//   slice_off bit offset of element (r,c) in a row-major 64-element packed block
package dct2d_pkg;

    localparam int COEF_W  = 32'd12;
    localparam int GUARD_C = 32'd3;
    localparam int ROUND_C = 32'd1024;
    localparam int SHIFT_C = 32'd11;

    localparam logic signed [COEF_W-1:0] K_TABLE [8][8] = '{
        '{ 12'sd724,   12'sd724,   12'sd724,   12'sd724,   12'sd724,   12'sd724,   12'sd724,   12'sd724 },
        '{ 12'sd1004,  12'sd851,   12'sd569,   12'sd200,  -12'sd200,  -12'sd569,  -12'sd851,  -12'sd1004 },
        '{ 12'sd946,   12'sd392,  -12'sd392,  -12'sd946,  -12'sd946,  -12'sd392,   12'sd392,   12'sd946 },
        '{ 12'sd851,  -12'sd200,  -12'sd1004, -12'sd569,   12'sd569,   12'sd1004,  12'sd200,  -12'sd851 },
        '{ 12'sd724,  -12'sd724,  -12'sd724,   12'sd724,   12'sd724,  -12'sd724,  -12'sd724,   12'sd724 },
        '{ 12'sd569,  -12'sd1004,  12'sd200,   12'sd851,  -12'sd851,  -12'sd200,   12'sd1004, -12'sd569 },
        '{ 12'sd392,  -12'sd946,   12'sd946,  -12'sd392,  -12'sd392,   12'sd946,  -12'sd946,   12'sd392 },
        '{ 12'sd200,  -12'sd569,   12'sd851,  -12'sd1004,  12'sd1004, -12'sd851,   12'sd569,  -12'sd200 }
    };

    // Element (0,0) sits in the most-significant slice.
    function automatic int slice_off(input int r, input int c, input int w);
        return (32'd63 - (32'd8 * r + c)) * w;
    endfunction

endpackage

// File: rtl/dct_2d_dct1d.sv
// dct1d_8: combinational 8-point 1D DCT-II.
//   s   8 signed IN_W-bit samples, element 0 in the top slice
//   y   8 signed OUT_W-bit results, element 0 in the top slice
//   y[k] = (sum_x K[k][x]*s[x] + 1024) >>> 11, then either truncated to
//   OUT_W (caller guarantees it fits) or clamped to the OUT_W range when SAT.
module dct1d_8
    import dct2d_pkg::*;
#(
    parameter int IN_W  = 32'd16,
    parameter int OUT_W = 32'd19,
    parameter int ACC_W = 32'd34,
    parameter bit SAT   = 1'b0
) (
    input  logic [8*IN_W-1:0]  s,
    output logic [8*OUT_W-1:0] y
);

    logic signed [ACC_W-1:0] acc_s [8];
    logic signed [ACC_W-1:0] shr_s [8];

    // Multiply-accumulate every output against its cosine row, then round.
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            acc_s[k] = ACC_W'(ROUND_C);
            for (int x = 0; x < 8; x++) begin
                acc_s[k] = acc_s[k]
                         + ACC_W'($signed(s[(7-x)*IN_W +: IN_W])) * ACC_W'(K_TABLE[k][x]);
            end
            shr_s[k] = acc_s[k] >>> SHIFT_C;
        end
    end

    // Narrow to the output width; out-of-range values clamp when SAT is set.
    always_comb begin
        y = '0;
        for (int k = 0; k < 8; k++) begin
            if (SAT && (shr_s[k][ACC_W-1:OUT_W-1] != {(ACC_W-OUT_W+1){shr_s[k][ACC_W-1]}})) begin
                y[(7-k)*OUT_W +: OUT_W] = shr_s[k][ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                                             : {1'b0, {(OUT_W-1){1'b1}}};
            end else begin
                y[(7-k)*OUT_W +: OUT_W] = shr_s[k][OUT_W-1:0];
            end
        end
    end

endmodule

// File: rtl/dct_2d.sv
// dct_2d: pipelined 8x8 forward DCT-II, one block per clock, 2-cycle latency.
//   clk        rising-edge clock
//   rst        asynchronous active-high reset, clears both stages
//   in_valid   data_in carries a block this cycle
//   data_in    64 signed N-bit samples, row-major, (0,0) in top slice
//   out_valid  data_out carries a finished block
//   data_out   64 signed N-bit coefficients, same packing, DC in top slice
// Stage 1 holds the row-pass results (N+3 bits each); stage 2 holds the
// saturated column-pass results and drives the outputs directly.
module dct_2d
    import dct2d_pkg::*;
#(
    parameter int N = 32'd16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [64*N-1:0] data_in,
    output logic            out_valid,
    output logic [64*N-1:0] data_out
);

    localparam int RW    = N + GUARD_C;
    localparam int ACC_W = N + GUARD_C + COEF_W + GUARD_C;

    logic [64*RW-1:0] row_next_s;
    logic [64*RW-1:0] s1_data_r;
    logic             s1_valid_r;
    logic [64*N-1:0]  col_next_s;
    logic [64*N-1:0]  s2_data_r;
    logic             s2_valid_r;

    // Row pass: row r of the input is a contiguous 8-element slice.
    for (genvar gr = 0; gr < 8; gr++) begin : g_row
        logic [8*RW-1:0] row_res_s;

        dct1d_8 #(
            .IN_W  (N),
            .OUT_W (RW),
            .ACC_W (ACC_W),
            .SAT   (1'b0)
        ) u_row (
            .s (data_in[(7-gr)*8*N +: 8*N]),
            .y (row_res_s)
        );

        assign row_next_s[(7-gr)*8*RW +: 8*RW] = row_res_s;
    end

    // Column pass: gather column v of the stage-1 block (the transpose) and
    // scatter result u back to coefficient (u,v).
    for (genvar gc = 0; gc < 8; gc++) begin : g_col
        logic [8*RW-1:0] col_in_s;
        logic [8*N-1:0]  col_res_s;

        for (genvar gr = 0; gr < 8; gr++) begin : g_tr
            assign col_in_s[(7-gr)*RW +: RW]          = s1_data_r[slice_off(gr, gc, RW) +: RW];
            assign col_next_s[slice_off(gr, gc, N) +: N] = col_res_s[(7-gr)*N +: N];
        end

        dct1d_8 #(
            .IN_W  (RW),
            .OUT_W (N),
            .ACC_W (ACC_W),
            .SAT   (1'b1)
        ) u_col (
            .s (col_in_s),
            .y (col_res_s)
        );
    end

    // Stage 1: row results, loaded only for valid blocks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_data_r  <= '0;
        end else begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                s1_data_r <= row_next_s;
            end
        end
    end

    // Stage 2: column results, loaded only when stage 1 holds a valid block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_r <= 1'b0;
            s2_data_r  <= '0;
        end else begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                s2_data_r <= col_next_s;
            end
        end
    end

    assign out_valid = s2_valid_r;
    assign data_out  = s2_data_r;

endmodule

// File: tb/tb_dct_2d.sv
module tb_dct_2d;

    localparam int N = 16;
    localparam int W = 64 * N;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] data_in;
    logic         out_valid;
    logic [W-1:0] data_out;

    always #5 clk = ~clk;

    dct_2d #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .data_in   (data_in),
        .out_valid (out_valid),
        .data_out  (data_out)
    );

    int errors = 0;
    int checks = 0;

    int kt   [8][8];
    int fin  [64];
    int fexp [64];

    // expected-output history: [0] driven last step, [1] driven two steps ago
    bit           hv [2];
    logic [W-1:0] hd [2];

    typedef struct {
        int fill;     // value of every sample
        int dcv;      // value of sample (0,0)
        int exp_dc;   // hand-computed F(0,0)
        bit ac_zero;  // all AC coefficients expected to be zero
    } vec_t;

    vec_t vecs [6];

    task automatic build(input int fill, input int dcv);
        for (int i = 0; i < 64; i++) fin[i] = fill;
        fin[0] = dcv;
    endtask

    // Reference fixed-point 2D DCT on fin -> fexp.
    task automatic model();
        longint t [8][8];
        longint acc;
        for (int r = 0; r < 8; r++)
            for (int k = 0; k < 8; k++) begin
                acc = 1024;
                for (int c = 0; c < 8; c++) acc += longint'(kt[k][c]) * longint'(fin[r*8+c]);
                t[r][k] = acc >>> 11;
            end
        for (int v = 0; v < 8; v++)
            for (int u = 0; u < 8; u++) begin
                acc = 1024;
                for (int x = 0; x < 8; x++) acc += longint'(kt[u][x]) * t[x][v];
                acc = acc >>> 11;
                if (acc > 32767) acc = 32767;
                if (acc < -32768) acc = -32768;
                fexp[u*8+v] = int'(acc);
            end
    endtask

    function automatic logic [W-1:0] pack_in();
        logic [W-1:0] p;
        for (int i = 0; i < 64; i++) p[(63-i)*N +: N] = fin[i][N-1:0];
        return p;
    endfunction

    function automatic logic [W-1:0] pack_exp();
        logic [W-1:0] p;
        for (int i = 0; i < 64; i++) p[(63-i)*N +: N] = fexp[i][N-1:0];
        return p;
    endfunction

    // One clock: check outputs for the block driven two steps earlier, then drive.
    task automatic step(input bit v, input logic [W-1:0] d, input logic [W-1:0] e);
        int bad;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== hv[1]) begin
            errors++;
            $display("FAIL out_valid at %0t: got %0b want %0b", $time, out_valid, hv[1]);
        end
        if (hv[1]) begin
            checks++;
            if (data_out !== hd[1]) begin
                errors++;
                bad = 0;
                for (int i = 63; i >= 0; i--)
                    if (data_out[(63-i)*N +: N] !== hd[1][(63-i)*N +: N]) bad = i;
                $display("FAIL block data at %0t coef %0d: got %0d want %0d", $time, bad,
                         $signed(data_out[(63-bad)*N +: N]), $signed(hd[1][(63-bad)*N +: N]));
            end
        end
        hv[1] = hv[0];
        hd[1] = hd[0];
        hv[0] = v;
        hd[0] = e;
        in_valid = v;
        data_in  = d;
    endtask

    task automatic idle();
        step(1'b0, '0, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        real pi, ck, rv;
        logic [W-1:0] blk_a, blk_b;

        pi = 3.14159265358979;
        for (int k = 0; k < 8; k++)
            for (int x = 0; x < 8; x++) begin
                ck = (k == 0) ? 1.0 / $sqrt(2.0) : 1.0;
                rv = 1024.0 * ck * $cos(real'((2*x+1)*k) * pi / 16.0);
                kt[k][x] = (rv >= 0.0) ? $rtoi(rv + 0.5) : -$rtoi(-rv + 0.5);
            end

        vecs[0] = '{fill: 100,    dcv: 100,    exp_dc: 800,    ac_zero: 1'b1};
        vecs[1] = '{fill: 0,      dcv: 0,      exp_dc: 0,      ac_zero: 1'b1};
        vecs[2] = '{fill: 255,    dcv: 255,    exp_dc: 2039,   ac_zero: 1'b1};
        vecs[3] = '{fill: 0,      dcv: 64,     exp_dc: 8,      ac_zero: 1'b0};
        vecs[4] = '{fill: 32767,  dcv: 32767,  exp_dc: 32767,  ac_zero: 1'b1};
        vecs[5] = '{fill: -32768, dcv: -32768, exp_dc: -32768, ac_zero: 1'b1};

        hv[0] = 1'b0; hv[1] = 1'b0; hd[0] = '0; hd[1] = '0;
        rst = 1'b1;
        in_valid = 1'b0;
        data_in = '0;

        #12;
        checks++;
        if (out_valid !== 1'b0 || data_out !== '0) begin
            errors++;
            $display("FAIL reset state: out_valid=%0b dc=%0d want 0/0", out_valid,
                     $signed(data_out[63*N +: N]));
        end
        rst = 1'b0;

        // Directed blocks, each followed by a flush so data_out holds the result.
        for (int i = 0; i < 6; i++) begin
            build(vecs[i].fill, vecs[i].dcv);
            model();
            step(1'b1, pack_in(), pack_exp());
            idle();
            idle();
            checks++;
            if ($signed(data_out[63*N +: N]) != vecs[i].exp_dc) begin
                errors++;
                $display("FAIL vec%0d dc: got %0d want %0d", i, $signed(data_out[63*N +: N]),
                         vecs[i].exp_dc);
            end
            checks++;
            if ((data_out[63*N-1:0] == '0) != vecs[i].ac_zero) begin
                errors++;
                $display("FAIL vec%0d ac_zero: got %0b want %0b", i, data_out[63*N-1:0] == '0,
                         vecs[i].ac_zero);
            end
        end

        // Random blocks, mostly back-to-back with occasional idle gaps.
        for (int b = 0; b < 256; b++) begin
            if ($urandom_range(0, 3) == 0) idle();
            for (int i = 0; i < 64; i++) fin[i] = int'($urandom_range(0, 255));
            model();
            step(1'b1, pack_in(), pack_exp());
        end
        idle();
        idle();
        idle();

        // Reset with two blocks in flight.
        build(10, 10);
        blk_a = pack_in();
        build(200, -5);
        blk_b = pack_in();
        step(1'b1, blk_a, '0);
        step(1'b1, blk_b, '0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        data_in = '0;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL async reset out_valid: got %0b want 0", out_valid);
        end
        checks++;
        if (data_out !== '0) begin
            errors++;
            $display("FAIL async reset data: got dc %0d want 0", $signed(data_out[63*N +: N]));
        end
        #10;
        rst = 1'b0;
        hv[0] = 1'b0; hv[1] = 1'b0; hd[0] = '0; hd[1] = '0;
        for (int i = 0; i < 4; i++) idle();

        // First block after release keeps the 2-cycle latency.
        build(100, 100);
        model();
        step(1'b1, pack_in(), pack_exp());
        idle();
        idle();
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
